// File: rtl/dta_egr_rcv_responder.sv
// Responder end of the egress req/resp/data transfer protocol.
// It grants each burst request up to the smaller of the receive-buffer
// credit and MAX_BURST. It then forwards exactly the granted number of data
// beats downstream and marks the final beat with tlast.
module dta_egr_rcv_responder #(
   parameter logic [15:0] MAX_BURST  = 16'd256,
   parameter int          CREDIT_MAX = 1024,
   parameter int          CREDIT_W   = 11
) (
   input  logic                ap_clk,
   input  logic                ap_rst,
   // request channel from the sender
   input  logic                req_tvalid,
   output logic                req_tready,
   input  logic [63:0]         req_tdata,
   // response (grant) channel back to the sender
   output logic                resp_tvalid,
   input  logic                resp_tready,
   output logic [63:0]         resp_tdata,
   // data beats from the sender
   input  logic                data_tvalid,
   output logic                data_tready,
   input  logic [511:0]        data_tdata,
   // data beats toward the downstream consumer
   output logic                m_data_tvalid,
   input  logic                m_data_tready,
   output logic [511:0]       m_data_tdata,
   output logic                m_data_tlast,
   // receive-buffer credit
   input  logic                credit_return,
   output logic [CREDIT_W-1:0] credit_avail,
   output logic [31:0]         granted_beats
);

   typedef enum logic [1:0] {
      IDLE,
      RESP,
      DATA
   } state_t;

   localparam int                 CW1         = CREDIT_W + 1;
   localparam logic [CW1-1:0]     CREDIT_SAT  = CW1'(CREDIT_MAX);
   localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);

   state_t      state;
   logic [15:0] grant;      // length granted for the burst in flight
   logic [15:0] beat_cnt;   // beats still expected in the data phase

   logic [15:0]    req_bl;
   logic [15:0]    grant_next;
   logic [CW1-1:0] credit_next;
   logic           req_hs;
   logic           resp_hs;
   logic           data_hs;

   // Reserved request bits carry no meaning for this block.
   logic unused_req_bits;
   assign unused_req_bits = ^req_tdata[47:34];

   assign req_bl = req_tdata[63:48];

   // Requests are taken in IDLE only. A zero-length request needs no credit,
   // so it is accepted even when the buffer is full. Reset holds ready low.
   assign req_tready = !ap_rst && (state == IDLE) &&
                       ((credit_avail != '0) || (req_bl == 16'd0));

   // Data passes straight through during the data phase and is stalled
   // (never dropped) in every other state.
   assign data_tready   = (state == DATA) && m_data_tready;
   assign m_data_tvalid = (state == DATA) && data_tvalid;
   assign m_data_tdata  = data_tdata;
   assign m_data_tlast  = (state == DATA) && (beat_cnt == 16'd1);

   assign req_hs  = req_tvalid && req_tready;
   assign resp_hs = resp_tvalid && resp_tready;
   assign data_hs = data_tvalid && data_tready;

   // Grant = min(requested length, MAX_BURST, available credit).
   always_comb begin
      logic [31:0] g;
      // NOTE: every variable written here gets a value on all paths first,
      // so no latch can be inferred.
      g = 32'(req_bl);
      if (g > 32'(MAX_BURST))    g = 32'(MAX_BURST);
      if (g > 32'(credit_avail)) g = 32'(credit_avail);
      grant_next = g[15:0];
   end

   // Net credit update: debit the grant on a request handshake and add one
   // per returned beat. A return has no effect once the count is at full scale.
   always_comb begin
      credit_next = {1'b0, credit_avail};
      if (req_hs)
         credit_next = credit_next - CW1'(grant_next);
      if (credit_return && (credit_next < CREDIT_SAT))
         credit_next = credit_next + CW1'(1);
   end

   // Protocol FSM with registered response, credit and grant accounting.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before this edge.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state         <= IDLE;
         grant         <= '0;
         beat_cnt      <= '0;
         resp_tvalid   <= 1'b0;
         resp_tdata    <= '0;
         credit_avail  <= CREDIT_FULL;
         granted_beats <= '0;
      end else begin
         credit_avail <= credit_next[CREDIT_W-1:0];
         case (state)
            IDLE: begin
               if (req_hs) begin
                  grant       <= grant_next;
                  resp_tdata  <= {grant_next, 14'd0, req_tdata[33:32], req_tdata[31:0]};
                  resp_tvalid <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (resp_hs) begin
                  resp_tvalid   <= 1'b0;
                  granted_beats <= granted_beats + 32'(grant);
                  if (grant == 16'd0) begin
                     state <= IDLE;
                  end else begin
                     beat_cnt <= grant;
                     state    <= DATA;
                  end
               end
            end
            DATA: begin
               if (data_hs) begin
                  beat_cnt <= beat_cnt - 16'd1;
                  if (beat_cnt == 16'd1)
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dta_egr_rcv_responder.sv
// Directed self-checking bench for dta_egr_rcv_responder.
module tb_dta_egr_rcv_responder;

   localparam int CW = 11;

   logic           ap_clk = 1'b0;
   logic           ap_rst;
   logic           req_tvalid;
   logic           req_tready;
   logic [63:0]    req_tdata;
   logic           resp_tvalid;
   logic           resp_tready;
   logic [63:0]    resp_tdata;
   logic           data_tvalid;
   logic           data_tready;
   logic [511:0]   data_tdata;
   logic           m_data_tvalid;
   logic           m_data_tready;
   logic [511:0]   m_data_tdata;
   logic           m_data_tlast;
   logic           credit_return;
   logic [CW-1:0]  credit_avail;
   logic [31:0]    granted_beats;

   int n_tests = 0;
   int n_fail  = 0;

   dta_egr_rcv_responder #(
      .MAX_BURST (16'd256),
      .CREDIT_MAX(1024),
      .CREDIT_W  (CW)
   ) dut (
      .ap_clk       (ap_clk),
      .ap_rst       (ap_rst),
      .req_tvalid   (req_tvalid),
      .req_tready   (req_tready),
      .req_tdata    (req_tdata),
      .resp_tvalid  (resp_tvalid),
      .resp_tready  (resp_tready),
      .resp_tdata   (resp_tdata),
      .data_tvalid  (data_tvalid),
      .data_tready  (data_tready),
      .data_tdata   (data_tdata),
      .m_data_tvalid(m_data_tvalid),
      .m_data_tready(m_data_tready),
      .m_data_tdata (m_data_tdata),
      .m_data_tlast (m_data_tlast),
      .credit_return(credit_return),
      .credit_avail (credit_avail),
      .granted_beats(granted_beats)
   );

   always #5 ap_clk = ~ap_clk;

   // Hard stop in case anything stalls beyond all bounded waits.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   function automatic logic [63:0] mk(input logic [15:0] bl, input logic [31:0] ch,
                                      input logic sof, input logic eof);
      return {bl, 14'd0, eof, sof, ch};
   endfunction

   function automatic logic [511:0] pat(input int k);
      return {16{32'(k) ^ 32'hA5A5_0000}};
   endfunction

   // Present a request and complete its handshake. Optionally pulse
   // credit_return in the handshake cycle. Then check resp latency and credit.
   task automatic send_req(input logic [15:0] bl, input logic [31:0] ch, input logic sof,
                           input logic eof, input logic cr, input int exp_credit);
      int n;
      req_tdata  = mk(bl, ch, sof, eof);
      req_tvalid = 1'b1;
      #1;
      n = 0;
      while (!req_tready && n < 50) begin
         step();
         n++;
      end
      check("req_tready", req_tready, 1);
      check("resp_before_hs", resp_tvalid, 0);
      credit_return = cr;
      step();
      req_tvalid    = 1'b0;
      credit_return = 1'b0;
      check("resp_latency", resp_tvalid, 1);
      check("credit_after_req", credit_avail, exp_credit);
   endtask

   // Hold resp_tready low for 'hold' cycles, then accept the response.
   task automatic take_resp(input logic [15:0] bl, input logic [31:0] ch, input logic sof,
                            input logic eof, input int hold, input int exp_granted);
      for (int i = 0; i < hold; i++) begin
         check("resp_hold_valid", resp_tvalid, 1);
         check("resp_hold_data", resp_tdata, mk(bl, ch, sof, eof));
         step();
      end
      check("resp_valid", resp_tvalid, 1);
      check("resp_data", resp_tdata, mk(bl, ch, sof, eof));
      resp_tready = 1'b1;
      step();
      resp_tready = 1'b0;
      check("resp_dropped", resp_tvalid, 0);
      check("granted_beats", granted_beats, exp_granted);
   endtask

   // Offer data continuously and consume n beats; downstream ready is either
   // held high or toggled every cycle.
   task automatic recv_data(input int n, input logic toggle);
      int k;
      int cyc;
      k = 0;
      cyc = 0;
      data_tvalid = 1'b1;
      while (k < n && cyc < 4 * n + 8) begin
         data_tdata    = pat(k);
         m_data_tready = toggle ? cyc[0] : 1'b1;
         #1;
         check("data_tready_mirror", data_tready, m_data_tready);
         check("m_data_tvalid", m_data_tvalid, 1);
         check("m_data_tdata", m_data_tdata, pat(k));
         check("m_data_tlast", m_data_tlast, (k == n - 1));
         if (m_data_tready) k++;
         step();
         cyc++;
      end
      check("beats_forwarded", k, n);
      m_data_tready = 1'b1;
      data_tdata    = pat(n);
      #1;
      check("no_data_after_last_rdy", data_tready, 0);
      check("no_data_after_last_vld", m_data_tvalid, 0);
      data_tvalid = 1'b0;
   endtask

   task automatic pulse_credit(input int exp_credit);
      credit_return = 1'b1;
      step();
      credit_return = 1'b0;
      check("credit_return", credit_avail, exp_credit);
   endtask

   initial begin
      ap_rst        = 1'b1;
      req_tvalid    = 1'b0;
      req_tdata     = '0;
      resp_tready   = 1'b0;
      data_tvalid   = 1'b0;
      data_tdata    = '0;
      m_data_tready = 1'b0;
      credit_return = 1'b0;

      // Reset state
      step();
      step();
      check("rst_req_tready", req_tready, 0);
      check("rst_resp_tvalid", resp_tvalid, 0);
      check("rst_resp_tdata", resp_tdata, 0);
      check("rst_data_tready", data_tready, 0);
      check("rst_m_data_tvalid", m_data_tvalid, 0);
      check("rst_m_data_tlast", m_data_tlast, 0);
      check("rst_credit", credit_avail, 1024);
      check("rst_granted", granted_beats, 0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      step();
      check("idle_req_tready", req_tready, 1);

      // Single burst bl=4 ch=5 sof=eof=1 with 5 cycles of resp backpressure
      send_req(16'd4, 32'd5, 1'b1, 1'b1, 1'b0, 1020);
      take_resp(16'd4, 32'd5, 1'b1, 1'b1, 5, 4);
      recv_data(4, 1'b0);
      check("credit_single", credit_avail, 1020);

      // Clamp by MAX_BURST: bl=300 -> 256
      send_req(16'd300, 32'd7, 1'b1, 1'b0, 1'b0, 764);
      take_resp(16'd256, 32'd7, 1'b1, 1'b0, 0, 260);
      recv_data(256, 1'b0);

      // Drain credit to 10
      send_req(16'd256, 32'd1, 1'b0, 1'b0, 1'b0, 508);
      take_resp(16'd256, 32'd1, 1'b0, 1'b0, 0, 516);
      recv_data(256, 1'b0);
      send_req(16'd256, 32'd1, 1'b0, 1'b0, 1'b0, 252);
      take_resp(16'd256, 32'd1, 1'b0, 1'b0, 0, 772);
      recv_data(256, 1'b0);
      send_req(16'd242, 32'd1, 1'b0, 1'b1, 1'b0, 10);
      take_resp(16'd242, 32'd1, 1'b0, 1'b1, 0, 1014);
      recv_data(242, 1'b0);

      // Grant of 2 at credit 10 with coincident credit_return -> 9
      send_req(16'd2, 32'd2, 1'b1, 1'b1, 1'b1, 9);
      take_resp(16'd2, 32'd2, 1'b1, 1'b1, 0, 1016);
      recv_data(2, 1'b0);

      // Bring credit to 3, then clamp by credit: bl=10 -> 3
      send_req(16'd6, 32'd3, 1'b0, 1'b0, 1'b0, 3);
      take_resp(16'd6, 32'd3, 1'b0, 1'b0, 0, 1022);
      recv_data(6, 1'b0);
      send_req(16'd10, 32'd4, 1'b1, 1'b0, 1'b0, 0);
      take_resp(16'd3, 32'd4, 1'b1, 1'b0, 0, 1025);
      recv_data(3, 1'b0);
      check("no_credit_req_tready", req_tready, 0);

      // Zero-length request at zero credit: accepted, no data phase
      send_req(16'd0, 32'd9, 1'b1, 1'b1, 1'b0, 0);
      take_resp(16'd0, 32'd9, 1'b1, 1'b1, 0, 1025);
      m_data_tready = 1'b1;
      data_tvalid   = 1'b1;
      #1;
      check("zero_len_no_data_rdy", data_tready, 0);
      check("zero_len_no_data_vld", m_data_tvalid, 0);
      check("zero_len_idle", req_tready, 1);
      check("zero_len_credit", credit_avail, 0);
      data_tvalid = 1'b0;
      req_tdata   = mk(16'd10, 32'd4, 1'b0, 1'b0);
      #1;
      check("zero_credit_blocks", req_tready, 0);
      pulse_credit(1);
      check("credit_unblocks", req_tready, 1);

      // 4-beat burst with toggling downstream ready
      pulse_credit(2);
      pulse_credit(3);
      pulse_credit(4);
      send_req(16'd4, 32'd3, 1'b0, 1'b1, 1'b0, 0);
      take_resp(16'd4, 32'd3, 1'b0, 1'b1, 0, 1029);
      recv_data(4, 1'b1);

      // Reset in the middle of a burst after 2 of 4 beats
      pulse_credit(1);
      pulse_credit(2);
      pulse_credit(3);
      pulse_credit(4);
      send_req(16'd4, 32'd6, 1'b1, 1'b1, 1'b0, 0);
      take_resp(16'd4, 32'd6, 1'b1, 1'b1, 0, 1033);
      m_data_tready = 1'b1;
      data_tvalid   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         data_tdata = pat(i);
         step();
      end
      #1;
      check("pre_rst_in_data", data_tready, 1);
      ap_rst = 1'b1;
      #1;
      check("mid_rst_req_tready", req_tready, 0);
      check("mid_rst_resp_tvalid", resp_tvalid, 0);
      check("mid_rst_resp_tdata", resp_tdata, 0);
      check("mid_rst_data_tready", data_tready, 0);
      check("mid_rst_m_data_tvalid", m_data_tvalid, 0);
      check("mid_rst_m_data_tlast", m_data_tlast, 0);
      check("mid_rst_credit", credit_avail, 1024);
      check("mid_rst_granted", granted_beats, 0);
      @(negedge ap_clk);
      ap_rst      = 1'b0;
      data_tvalid = 1'b0;
      step();

      // Return at CREDIT_MAX is ignored
      pulse_credit(1024);

      // Normal request after reset
      send_req(16'd4, 32'd2, 1'b1, 1'b1, 1'b0, 1020);
      take_resp(16'd4, 32'd2, 1'b1, 1'b1, 0, 4);
      recv_data(4, 1'b0);
      check("final_credit", credit_avail, 1020);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dta_egr_rcv_responder.md
Name: dta_egr_rcv_responder

Overview:
Responder end of the egress req/resp/data transfer protocol. It accepts a burst request from the sender and grants it on resp. The grant length is limited by the receive-buffer credit and by MAX_BURST. It then accepts exactly the granted number of 512-bit data beats and forwards them downstream with tlast on the final beat. It sits opposite the egress sender, so the egress send monitor sees legal traffic on every channel.

Parameters:
MAX_BURST, 16'd256, largest burst_length granted per resp (beats); must be ≥1.
CREDIT_MAX, 1024, receive-buffer depth in beats; credit counter reset and saturation value.
CREDIT_W, 11, credit counter width; must satisfy 2^CREDIT_W > CREDIT_MAX.

Ports:
ap_clk  in  1  clock; all logic on rising edge.
ap_rst  in  1  asynchronous, active-high reset.
req_tvalid  in  1  request valid.
req_tready  out  1  request ready.
req_tdata  in  64  [63:48] burst_length, [33] eof, [32] sof, [31:0] channel; other bits ignored.
resp_tvalid  out  1  response valid.
resp_tready  in  1  response ready.
resp_tdata  out  64  same field layout as req; reserved bits driven 0.
data_tvalid  in  1  sender data valid.
data_tready  out  1  sender data ready.
data_tdata  in  512  sender data beat.
m_data_tvalid  out  1  downstream valid.
m_data_tready  in  1  downstream ready.
m_data_tdata  out  512  downstream data (pass-through).
m_data_tlast  out  1  high on the last granted beat of a burst.
credit_return  in  1  one-cycle pulse; one buffer beat freed.
credit_avail  out  CREDIT_W  current credit count.
granted_beats  out  32  running total of granted beats; wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE
  - req_tready=0, resp_tvalid=0, resp_tdata=0
  - data_tready=0, m_data_tvalid=0, m_data_tlast=0
  - credit_avail=CREDIT_MAX
  - granted_beats=0
- Reset mid-burst discards the burst and drops any partial resp.
- FSM states: IDLE, RESP, DATA.
- IDLE:
  - req_tready = (credit_avail≠0) || (req_tdata[63:48]==0), combinational.
  - On req handshake, register grant = min(req_bl, MAX_BURST, credit_avail).
  - Copy channel, sof and eof from the request into the response.
  - Go to RESP.
- RESP:
  - resp_tvalid=1 with resp_tdata stable until resp_tready.
  - On handshake with grant=0: go to IDLE; no data phase.
  - On handshake with grant≥1: go to DATA, beat_cnt=grant.
- Request latency: resp_tvalid rises exactly 1 cycle after the req handshake.
- Credit accounting:
  - Credit is debited by grant in the req-handshake cycle.
  - credit_return adds 1 in the same cycle; both events can occur in one cycle with net update.
  - The counter saturates at CREDIT_MAX. A return at CREDIT_MAX is ignored and never wraps.
- granted_beats adds grant at the resp handshake.
- DATA:
  - data_tready=m_data_tready, m_data_tvalid=data_tvalid, m_data_tdata=data_tdata (combinational pass-through, zero latency).
  - m_data_tlast = (beat_cnt==1).
  - Each data handshake decrements beat_cnt. On the handshake with beat_cnt==1, go to IDLE.
  - Next req is accepted no earlier than the following cycle; one burst outstanding at most.
- Outside DATA: data_tready=0 and m_data_tvalid=0; sender data is stalled, never dropped.
- The granted length is never larger than the requested length. Requests with burst_length 0 are answered with a 0-length resp.
- No combinational path from req_tvalid to resp_tvalid.

Test Plan:
- Single burst: credit 1024, req bl=4 ch=5 sof=eof=1 -> resp 1 cycle later with bl=4 ch=5 sof=eof=1; 4 data beats forwarded; tlast on beat 4; credit_avail=1020; granted_beats=4.
- Clamp by credit and by max: credit 3, req bl=10 -> resp bl=3, credit_avail=0, req_tready=0 until credit_return. Separately, req bl=300 with full credit -> resp bl=256.
- Zero-length request: req bl=0 with credit_avail=0 -> accepted; resp bl=0; no data phase; credit_avail unchanged; back in IDLE.
- Backpressure: resp_tready held low 5 cycles -> resp_tdata stable. m_data_tready toggling during a 4-beat burst -> data_tready mirrors it; exactly 4 beats pass; no data accepted after tlast.
- Credit edges: credit_return coincident with a grant of 2 at credit 10 -> 9. credit_return at CREDIT_MAX -> stays 1024.
- Reset mid-DATA after 2 of 4 beats -> all outputs return to reset values at once, credit_avail=1024. Next req is handled normally.
